agc_quant2: RTL and testbench

- Digital AGC and 2-bit quantizer sitting directly downstream of the DC-offset remover.
- Takes that stage's signed, zero-mean sample stream and outputs sign/magnitude bits for the correlators.
- Adapts the magnitude threshold so the fraction of samples with |x| > thr tracks a programmed target (≈32 % for GNSS 2-bit).
- Exposes the threshold, a lock flag and per-window statistics for software.

---
 rtl/agc_pkg.sv | 30 +++
 rtl/agc_win_stat.sv | 44 ++++
 rtl/agc_quant2.sv | 113 +++++++++++
 tb/tb_agc_quant2.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/agc_pkg.sv
// Shared definitions for the AGC / 2-bit quantizer: FSM encoding, adaptation
// factors and the saturating threshold step helper.
package agc_pkg;

  typedef enum logic {
    ACQ   = 1'b0,
    TRACK = 1'b1
  } agc_state_t;

  localparam int ACQ_STEP_MULT = 4;
  localparam int LOCK_LOSS_MULT = 4;

  // Steps cur by s toward hi (up=1) or lo (up=0), clamping at the bound.
  // Evaluated on 32 bits so cur+s can never wrap for any legal threshold.
  function automatic logic [31:0] sat_step(
    input logic [31:0] cur,
    input logic [31:0] s,
    input logic [31:0] lo,
    input logic [31:0] hi,
    input logic        up
  );
    logic [32:0] sum;
    sum = {1'b0, cur} + {1'b0, s};
    if (up)
      return (sum > {1'b0, hi}) ? hi : sum[31:0];
    else
      return (cur < lo + s) ? lo : cur - s;
  endfunction

endpackage

// File: rtl/agc_win_stat.sv
// Window statistics: counts quantizer outputs per 2^win_log2 window, totals the
// above-threshold hits and strobes win_end on the last sample of each window.
module agc_win_stat
  import agc_pkg::*;
#(
  parameter int win_log2 = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                q_valid,
  input  logic                q_mag,
  output logic                win_end,
  output logic [win_log2:0]   total,
  output logic [win_log2:0]   hi_cnt_last
);

  logic [win_log2-1:0] win_cnt;
  logic [win_log2-1:0] hi_cnt;

  // The last sample's hit is folded in combinationally so the new window
  // starts from zero on the very next sample.
  assign win_end = q_valid && (win_cnt == '1);
  assign total   = {1'b0, hi_cnt} + (win_log2 + 1)'(q_mag);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt     <= '0;
      hi_cnt      <= '0;
      hi_cnt_last <= '0;
    end else if (q_valid) begin
      if (win_end) begin
        win_cnt     <= '0;
        hi_cnt      <= '0;
        hi_cnt_last <= total;
      end else begin
        win_cnt <= win_cnt + win_log2'(1);
        hi_cnt  <= hi_cnt + win_log2'(q_mag);
      end
    end
  end

endmodule

// File: rtl/agc_quant2.sv
// Digital AGC with 2-bit (sign/magnitude) quantizer; adapts the magnitude
// threshold so the per-window count of |x| > thr tracks the programmed target.
module agc_quant2
  import agc_pkg::*;
#(
  parameter int width    = 14,
  parameter int win_log2 = 10,
  parameter int target   = 328,
  parameter int hyst     = 16,
  parameter int step     = 4,
  parameter int thr_init = 2048,
  parameter int thr_min  = 16,
  parameter int thr_max  = 8000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [width-1:0] DAT_in,
  input  logic                    agc_en,
  input  logic [width-2:0]        thr_manual,
  output logic                    q_sign,
  output logic                    q_mag,
  output logic [width-2:0]        thr,
  output logic                    thr_upd,
  output logic [win_log2:0]       hi_cnt_last,
  output logic                    locked
);

  agc_state_t         state;
  logic               s1_sign;
  logic [width-2:0]   s1_mag;
  logic [width-2:0]   mag_c;
  logic               v1, v2;
  logic               win_end;
  logic [win_log2:0]  total;

  int                 tot_i, diff_abs, step_s;
  logic               over, under;
  logic [width-2:0]   thr_nxt;
  agc_state_t         state_nxt;

  // Negative magnitude is the low bits of the two's complement negation;
  // the most negative code has no positive twin and saturates instead.
  always_comb begin
    mag_c = DAT_in[width-2:0];
    if (DAT_in[width-1])
      mag_c = (DAT_in[width-2:0] == '0) ? '1 : (~DAT_in[width-2:0]) + (width-1)'(1);
  end

  agc_win_stat #(.win_log2(win_log2)) u_win_stat (
    .clk         (clk),
    .reset       (reset),
    .q_valid     (v2),
    .q_mag       (q_mag),
    .win_end     (win_end),
    .total       (total),
    .hi_cnt_last (hi_cnt_last)
  );

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    tot_i     = int'(total);
    step_s    = (state == TRACK) ? step : step * ACQ_STEP_MULT;
    over      = tot_i > target + hyst;
    under     = tot_i < target - hyst;
    diff_abs  = (tot_i >= target) ? tot_i - target : target - tot_i;
    thr_nxt   = thr;
    state_nxt = state;
    if (over)
      thr_nxt = (width-1)'(sat_step(32'(thr), step_s, thr_min, thr_max, 1'b1));
    else if (under)
      thr_nxt = (width-1)'(sat_step(32'(thr), step_s, thr_min, thr_max, 1'b0));
    if (state == ACQ && !over && !under)
      state_nxt = TRACK;
    else if (state == TRACK && diff_abs > LOCK_LOSS_MULT * hyst)
      state_nxt = ACQ;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_sign <= 1'b0;
      s1_mag  <= '0;
      q_sign  <= 1'b0;
      q_mag   <= 1'b0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      thr     <= (width-1)'(thr_init);
      thr_upd <= 1'b0;
      state   <= ACQ;
    end else begin
      s1_sign <= DAT_in[width-1];
      s1_mag  <= mag_c;
      q_sign  <= s1_sign;
      q_mag   <= s1_mag > thr;
      v1      <= 1'b1;
      v2      <= v1;
      if (!agc_en) begin
        thr     <= thr_manual;
        thr_upd <= 1'b0;
        state   <= ACQ;
      end else begin
        thr_upd <= win_end;
        if (win_end) begin
          thr   <= thr_nxt;
          state <= state_nxt;
        end
      end
    end
  end

  assign locked = (state == TRACK);

endmodule

// File: tb/tb_agc_quant2.sv
// Directed self-checking bench for agc_quant2 with a 16-sample window.
module tb_agc_quant2;

  localparam int WIDTH = 14;
  localparam int WL2   = 4;

  logic                    clk = 1'b0;
  logic                    reset;
  logic signed [WIDTH-1:0] DAT_in;
  logic                    agc_en;
  logic [WIDTH-2:0]        thr_manual;
  logic                    q_sign, q_mag, thr_upd, locked;
  logic [WIDTH-2:0]        thr;
  logic [WL2:0]            hi_cnt_last;

  int n_checks = 0;
  int n_fail   = 0;

  agc_quant2 #(
    .width(WIDTH), .win_log2(WL2), .target(5), .hyst(1), .step(16),
    .thr_init(1024), .thr_min(16), .thr_max(2000)
  ) dut (
    .clk(clk), .reset(reset), .DAT_in(DAT_in), .agc_en(agc_en),
    .thr_manual(thr_manual), .q_sign(q_sign), .q_mag(q_mag), .thr(thr),
    .thr_upd(thr_upd), .hi_cnt_last(hi_cnt_last), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset across two edges and release it just after a rising edge.
  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Advance until thr_upd is seen; returns edges taken, or -1 on timeout.
  task automatic wait_upd(input string tag, output int edges);
    edges = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (thr_upd) begin
        edges = i;
        break;
      end
    end
    if (edges < 0) check({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    int e, exp_thr, upd_seen;

    // 1: reset values, then two empty windows pull thr down by 64 each
    reset = 1'b1; DAT_in = '0; agc_en = 1'b1; thr_manual = '0;
    #1;
    check("rst_q_sign", q_sign, 0);
    check("rst_q_mag", q_mag, 0);
    check("rst_thr", thr, 1024);
    check("rst_locked", locked, 0);
    check("rst_thr_upd", thr_upd, 0);
    check("rst_hi_last", hi_cnt_last, 0);
    tick();
    reset = 1'b0;
    wait_upd("t1_w1", e);
    check("t1_thr_w1", thr, 960);
    wait_upd("t1_w2", e);
    check("t1_thr_w2", thr, 896);
    check("t1_hi_last", hi_cnt_last, 0);
    check("t1_locked", locked, 0);

    // 2: constant -3000, two-cycle latency, thr climbs 64/window to 2000
    DAT_in = -14'sd3000;
    do_reset();
    tick();
    check("t2_lat1_sign", q_sign, 0);
    tick();
    check("t2_lat2_sign", q_sign, 1);
    check("t2_lat2_mag", q_mag, 1);
    exp_thr = 1024;
    for (int w = 0; w < 17; w++) begin
      wait_upd("t2_upd", e);
      exp_thr = (exp_thr + 64 > 2000) ? 2000 : exp_thr + 64;
      check($sformatf("t2_thr_w%0d", w), thr, exp_thr);
    end
    check("t2_hi_last", hi_cnt_last, 16);
    check("t2_locked", locked, 0);

    // 3: magnitude saturation and strict compare with manual thr=1024
    agc_en = 1'b0; thr_manual = 13'd1024;
    tick();
    check("t3_manual_thr", thr, 1024);
    DAT_in = -14'sd8192; tick(); tick();
    check("t3_min_sign", q_sign, 1);
    check("t3_min_mag", q_mag, 1);
    DAT_in = 14'sd1024; tick(); tick();
    check("t3_eq_mag", q_mag, 0);
    check("t3_eq_sign", q_sign, 0);
    DAT_in = 14'sd1025; tick(); tick();
    check("t3_gt_mag", q_mag, 1);
    DAT_in = -14'sd1024; tick(); tick();
    check("t3_neg_eq_mag", q_mag, 0);
    check("t3_neg_eq_sign", q_sign, 1);

    // 4: window with exactly 5 hits locks; a full window then loses lock
    agc_en = 1'b1;
    DAT_in = '0;
    do_reset();
    for (int k = 1; k <= 34; k++) begin
      DAT_in = (k - 1 >= 16 || (k - 1) % 3 == 1) ? 14'sd1500 : 14'sd0;
      tick();
      if (k == 17) check("t4_upd_pre", thr_upd, 0);
      if (k == 18) begin
        check("t4_upd_w1", thr_upd, 1);
        check("t4_hi_w1", hi_cnt_last, 5);
        check("t4_thr_w1", thr, 1024);
        check("t4_lock_w1", locked, 1);
      end
      if (k == 19) check("t4_upd_once", thr_upd, 0);
      if (k == 34) begin
        check("t4_upd_w2", thr_upd, 1);
        check("t4_hi_w2", hi_cnt_last, 16);
        check("t4_thr_w2", thr, 1040);
        check("t4_lock_w2", locked, 0);
      end
    end

    // 5: manual mode, no updates, statistics keep running
    agc_en = 1'b0; thr_manual = 13'd500; DAT_in = '0;
    check("t5_thr_before", thr, 1040);
    tick();
    check("t5_thr_manual", thr, 500);
    upd_seen = 0;
    for (int k = 0; k < 48; k++) begin
      tick();
      if (thr_upd) upd_seen++;
    end
    check("t5_no_upd", upd_seen, 0);
    check("t5_hi_last", hi_cnt_last, 0);
    check("t5_locked", locked, 0);

    // 6: reset at window sample 9 with thr=1300, then a full first window
    agc_en = 1'b0; thr_manual = 13'd1300; DAT_in = -14'sd3000;
    do_reset();
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 3) agc_en = 1'b1;
    end
    check("t6_pre_thr", thr, 1300);
    check("t6_pre_sign", q_sign, 1);
    reset = 1'b1;
    #1;
    check("t6_rst_sign", q_sign, 0);
    check("t6_rst_mag", q_mag, 0);
    check("t6_rst_thr", thr, 1024);
    check("t6_rst_locked", locked, 0);
    check("t6_rst_upd", thr_upd, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_upd("t6_upd", e);
    check("t6_upd_edges", e, 18);
    check("t6_thr", thr, 1088);
    check("t6_hi_last", hi_cnt_last, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
